// File: rtl/adder_pkg.sv
// Shared constants and FSM encoding for the nibble-serial adder.
// Imported by the slice and the sequencing controller.
package adder_pkg;

   localparam int SLICE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/cla4_slice.sv
// 4-bit carry-look-ahead slice: generate/propagate with
// fully expanded carries, no ripple between bit positions.
module cla4_slice
   import adder_pkg::*;
(
   input  logic [SLICE_W-1:0] a,
   input  logic [SLICE_W-1:0] b,
   input  logic               cin,
   output logic [SLICE_W-1:0] s,
   output logic               cout
);

   logic [SLICE_W-1:0] g;
   logic [SLICE_W-1:0] p;
   logic [SLICE_W:0]   c;

   assign g = a & b;
   assign p = a ^ b;

   assign c[0] = cin;
   assign c[1] = g[0] | (p[0] & cin);
   assign c[2] = g[1] | (p[1] & g[0])
               | (p[1] & p[0] & cin);
   assign c[3] = g[2] | (p[2] & g[1])
               | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & cin);
   assign c[4] = g[3] | (p[3] & g[2])
               | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & cin);

   assign s    = p ^ c[SLICE_W-1:0];
   assign cout = c[SLICE_W];

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial add/subtract: one CLA slice reused over N_NIB
// cycles, LSB nibble first, carry held in a register between nibbles.
module nibble_serial_add_ctrl
   import adder_pkg::*;
#(
   parameter int N_NIB = 4
)(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [SLICE_W*N_NIB-1:0] A,
   input  logic [SLICE_W*N_NIB-1:0] B,
   input  logic                   cin,
   input  logic                   sub,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [SLICE_W*N_NIB-1:0] S,
   output logic                   cout,
   output logic                   ovf
);

   localparam int W  = SLICE_W * N_NIB;
   localparam int KW = (N_NIB > 1) ? $clog2(N_NIB) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(N_NIB - 1);

   state_t state;
   state_t state_nxt;

   logic [W-1:0]       a_q;
   logic [W-1:0]       b_q;
   logic [W-1:0]       s_acc;
   logic [W-1:0]       s_full;
   logic               carry;
   logic [KW-1:0]      k;
   logic [SLICE_W-1:0] nib_a;
   logic [SLICE_W-1:0] nib_b;
   logic [SLICE_W-1:0] nib_s;
   logic               nib_c;
   logic               accept;
   logic               last;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (in_valid)   state_nxt = RUN;
         RUN:  if (k == K_LAST) state_nxt = DONE;
         DONE: if (out_ready)  state_nxt = IDLE;
         default:              state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready = (state == IDLE);
      accept   = in_ready & in_valid;
      last     = (state == RUN) && (k == K_LAST);
   end

   assign nib_a = a_q[{k, 2'b00} +: SLICE_W];
   assign nib_b = b_q[{k, 2'b00} +: SLICE_W];

   cla4_slice u_slice (
      .a    (nib_a),
      .b    (nib_b),
      .cin  (carry),
      .s    (nib_s),
      .cout (nib_c)
   );

   always_comb begin
      s_full = s_acc;
      s_full[{k, 2'b00} +: SLICE_W] = nib_s;
   end

   // S/cout/ovf only move on the final nibble, so they hold
   // the previous result throughout RUN.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_q       <= '0;
         b_q       <= '0;
         s_acc     <= '0;
         carry     <= 1'b0;
         k         <= '0;
         S         <= '0;
         cout      <= 1'b0;
         ovf       <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= (state_nxt == DONE);
         if (accept) begin
            a_q   <= A;
            b_q   <= sub ? ~B : B;
            carry <= sub | cin;
            k     <= '0;
         end else if (state == RUN) begin
            s_acc <= s_full;
            carry <= nib_c;
            if (!last) k <= k + KW'(1);
            if (last) begin
               S    <= s_full;
               cout <= nib_c;
               ovf  <= (a_q[W-1] == b_q[W-1])
                    && (nib_s[SLICE_W-1] != a_q[W-1]);
            end
         end
      end
   end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed bench for nibble_serial_add_ctrl at N_NIB=4.
// Each task drives one scenario and checks its own results.
module tb_nibble_serial_add_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] A;
   logic [15:0] B;
   logic        cin;
   logic        sub;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] S;
   logic        cout;
   logic        ovf;

   int pass_cnt = 0;
   int chk_cnt  = 0;

   always #5 clk = ~clk;

   nibble_serial_add_ctrl #(.N_NIB(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .S         (S),
      .cout      (cout),
      .ovf       (ovf)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Accepts one op, then waits (bounded) for out_valid.
   task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                         input logic c, input logic sb,
                         output int lat);
      A = a; B = b; cin = c; sub = sb; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
      end
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      chk_cnt++;
      if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready);
      else pass_cnt++;
      chk_cnt++;
      if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid);
      else pass_cnt++;
      chk_cnt++;
      if (S !== 16'h0000) $display("FAIL reset_S got %h want 0000", S);
      else pass_cnt++;
      chk_cnt++;
      if ({cout, ovf} !== 2'b00) $display("FAIL reset_flags got %b want 00", {cout, ovf});
      else pass_cnt++;
   endtask

   task automatic test_vec(input string nm,
                           input logic [15:0] a, input logic [15:0] b,
                           input logic c, input logic sb,
                           input logic [15:0] es, input logic ec,
                           input logic eo);
      int lat;
      run_op(a, b, c, sb, lat);
      chk_cnt++;
      if (lat !== 4) $display("FAIL %s_latency got %0d want 4", nm, lat);
      else pass_cnt++;
      chk_cnt++;
      if (S !== es) $display("FAIL %s_S got %h want %h", nm, S, es);
      else pass_cnt++;
      chk_cnt++;
      if (cout !== ec) $display("FAIL %s_cout got %b want %b", nm, cout, ec);
      else pass_cnt++;
      chk_cnt++;
      if (ovf !== eo) $display("FAIL %s_ovf got %b want %b", nm, ovf, eo);
      else pass_cnt++;
      handshake();
      chk_cnt++;
      if ({in_ready, out_valid} !== 2'b10)
         $display("FAIL %s_after_hs got %b want 10", nm, {in_ready, out_valid});
      else pass_cnt++;
      chk_cnt++;
      if (S !== es) $display("FAIL %s_S_hold got %h want %h", nm, S, es);
      else pass_cnt++;
   endtask

   task automatic test_inflight();
      A = 16'h0F0F; B = 16'h0101; cin = 1'b0; sub = 1'b0;
      in_valid = 1'b1;
      tick();
      A = 16'hFFFF; B = 16'hFFFF; cin = 1'b1; sub = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk_cnt++;
         if ({in_ready, out_valid} !== 2'b00)
            $display("FAIL inflight_run_flags got %b want 00", {in_ready, out_valid});
         else pass_cnt++;
         chk_cnt++;
         if (S !== 16'h7FFF) $display("FAIL inflight_S_prev got %h want 7fff", S);
         else pass_cnt++;
         A = A ^ 16'h5A5A;
         tick();
      end
      tick();
      in_valid = 1'b0;
      chk_cnt++;
      if (out_valid !== 1'b1) $display("FAIL inflight_valid got %b want 1", out_valid);
      else pass_cnt++;
      chk_cnt++;
      if ({S, cout, ovf} !== {16'h1010, 2'b00})
         $display("FAIL inflight_result got %h/%b%b want 1010/00", S, cout, ovf);
      else pass_cnt++;
      handshake();
   endtask

   task automatic test_hold();
      int lat;
      run_op(16'h7000, 16'h1000, 1'b0, 1'b0, lat);
      chk_cnt++;
      if (lat !== 4) $display("FAIL hold_latency got %0d want 4", lat);
      else pass_cnt++;
      for (int i = 0; i < 3; i++) begin
         A = 16'h1234 + 16'(i); B = ~A; in_valid = 1'b1; sub = i[0];
         chk_cnt++;
         if ({S, cout, ovf} !== {16'h8000, 2'b01})
            $display("FAIL hold_result got %h/%b%b want 8000/01", S, cout, ovf);
         else pass_cnt++;
         chk_cnt++;
         if ({in_ready, out_valid} !== 2'b01)
            $display("FAIL hold_flags got %b want 01", {in_ready, out_valid});
         else pass_cnt++;
         tick();
      end
      in_valid = 1'b0;
      handshake();
      chk_cnt++;
      if ({in_ready, out_valid} !== 2'b10)
         $display("FAIL hold_release got %b want 10", {in_ready, out_valid});
      else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      A = 16'h1234; B = 16'h1111; cin = 1'b0; sub = 1'b0;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk_cnt++;
      if ({in_ready, out_valid} !== 2'b10)
         $display("FAIL rstmid_flags got %b want 10", {in_ready, out_valid});
      else pass_cnt++;
      chk_cnt++;
      if ({S, cout, ovf} !== 18'h0)
         $display("FAIL rstmid_outputs got %h/%b%b want 0000/00", S, cout, ovf);
      else pass_cnt++;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk_cnt++;
         if (out_valid !== 1'b0) $display("FAIL rstmid_no_valid got %b want 0", out_valid);
         else pass_cnt++;
      end
      test_vec("rstmid_fresh", 16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      A = '0; B = '0; cin = 1'b0; sub = 1'b0;
      test_reset();
      test_vec("add_basic", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
      test_vec("ripple",    16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      test_vec("pos_ovf",   16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1);
      test_vec("sub_neg",   16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      test_vec("sub_ovf",   16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
      test_inflight();
      test_hold();
      test_vec("back_to_back", 16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
      test_vec("sub_wrap", 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/nibble_serial_add_ctrl.md
NIBBLE_SERIAL_ADD_CTRL -- requirements
Module: nibble_serial_add_ctrl

Interface
REQ-001 Parameter: N_NIB, default 4, number of 4-bit slices per operand (operand width W = 4*N_NIB); legal range 1..16.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  operand pair and mode present.
REQ-005 in_ready  output  1  controller can accept an operation.
REQ-006 A  input  W  operand A.
REQ-007 B  input  W  operand B.
REQ-008 cin  input  1  external carry-in, used when sub=0.
REQ-009 sub  input  1  0 = A+B+cin; 1 = A-B (A + ~B + 1).
REQ-010 out_valid  output  1  result registered and stable.
REQ-011 out_ready  input  1  consumer takes result.
REQ-012 S  output  W  sum or difference.
REQ-013 cout  output  1  carry out of bit W-1 (sub=1: 1 = no borrow).
REQ-014 ovf  output  1  two's-complement signed overflow.

Function
REQ-015 Controller SHALL sequence one 4-bit carry-look-ahead slice over N_NIB cycles, LSB nibble first; a registered carry links successive nibbles.
REQ-016 FSM states SHALL be IDLE, RUN, DONE.
REQ-017 IDLE: in_ready=1; on in_valid=1, SHALL capture A, B (inverted if sub=1), sub, and carry seed (cin if sub=0, 1 if sub=1); set index k=0; go RUN.
REQ-018 RUN: each cycle, slice SHALL add nibble k of captured A, B with carry register; write nibble k of S register; update carry register with slice carry-out; k increments.
REQ-019 RUN with k=N_NIB-1 SHALL go DONE on the next edge; cout = final carry; ovf = (A[W-1] == B'[W-1]) && (S[W-1] != A[W-1]), where B' is the captured (possibly inverted) B.
REQ-020 Latency: out_valid SHALL rise exactly N_NIB edges after the accepting edge.
REQ-021 DONE: out_valid=1; S, cout, ovf SHALL stay constant until out_ready=1 is sampled; then go IDLE.
REQ-022 in_ready SHALL be 0 in RUN and DONE; no accept in the same cycle as the out_valid/out_ready handshake; minimum spacing between operations is N_NIB+2 cycles.
REQ-023 Changes on A, B, cin, sub, in_valid after acceptance SHALL NOT affect the operation in flight.
REQ-024 out_valid SHALL be 0 in IDLE and RUN; S SHALL hold last completed result outside DONE.
REQ-025 Index k SHALL be ceil(log2(N_NIB)) bits wide (min 1); no wrap beyond N_NIB-1.
REQ-026 All outputs SHALL be registered; no combinational path from inputs to outputs except in_ready from state.

Reset
REQ-027 rst_n=0 at a rising edge SHALL force IDLE, k=0, carry=0, S=0, cout=0, ovf=0, out_valid=0; in_ready=1 after reset release.
REQ-028 Reset during RUN or DONE SHALL discard the in-flight operation without emitting out_valid.

Structure
REQ-029 Shared package adder_pkg SHALL hold the slice-width constant (4) and FSM state encoding (IDLE=0, RUN=1, DONE=2, 2 bits).
REQ-030 One sub-module, cla4_slice (4-bit generate/propagate look-ahead adder: A, B, cin -> S, cout), SHALL be instantiated once.

Verification (N_NIB=4)
REQ-031 0x1234 + 0x4321, cin=0, sub=0 -> S=0x5555, cout=0, ovf=0; out_valid 4 cycles after accept.
REQ-032 0xFFFF + 0x0001, cin=0 -> S=0x0000, cout=1, ovf=0 (carry ripples through all slices).
REQ-033 0x7FFF + 0x0000, cin=1 -> S=0x8000, cout=0, ovf=1.
REQ-034 sub=1, 0x0005 - 0x0007 -> S=0xFFFE, cout=0, ovf=0; sub=1, 0x8000 - 0x0001 -> S=0x7FFF, cout=1, ovf=1.
REQ-035 out_ready held 0 for 3 cycles in DONE; A/B toggled meanwhile -> S, cout, ovf unchanged, in_valid ignored, in_ready=0.
REQ-036 rst_n=0 for one edge at RUN cycle k=2 -> next cycle IDLE, all outputs 0, no out_valid; fresh op afterwards completes correctly.
